// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one external multiplier between NREQ clients.
// Optional MULT_ARB_STATS_EN adds the issue_cnt accept counter.
module mult_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 0,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  issue_en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      m_a,
    output logic [WIDTH-1:0]      m_b,
    input  logic [2*WIDTH-1:0]    m_result,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_result
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]           issue_cnt
`endif
);

    logic [IDW-1:0]     r_ptr;
    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_gid;
    logic               w_fire;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    logic [WIDTH-1:0]   r_m_a;
    logic [WIDTH-1:0]   r_m_b;
    logic [MULT_LAT:0]  r_tag_v;
    logic [IDW-1:0]     r_tag_id [MULT_LAT+1];
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;

    // First valid requester at or above the pointer wins, wrapping to 0.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_grant = '0;
        w_gid   = '0;
        w_fire  = 1'b0;
        if (clr_n && issue_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!w_fire && req_valid[idx]) begin
                    w_fire       = 1'b1;
                    w_gid        = IDW'(idx);
                    w_grant[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign w_a       = req_a[w_gid*WIDTH +: WIDTH];
    assign w_b       = req_b[w_gid*WIDTH +: WIDTH];
    assign w_ptr_nxt = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ptr <= '0;
            r_m_a <= '0;
            r_m_b <= '0;
        end else if (w_fire) begin
            r_ptr <= w_ptr_nxt;
            r_m_a <= w_a;
            r_m_b <= w_b;
        end
    end

    // Tag stages track the multiplier depth so ids line up with products.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tag_v <= '0;
            for (int s = 0; s <= MULT_LAT; s++) r_tag_id[s] <= '0;
        end else begin
            r_tag_v[0] <= w_fire;
            if (w_fire) r_tag_id[0] <= w_gid;
            for (int s = 1; s <= MULT_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else if (r_tag_v[MULT_LAT]) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_tag_id[MULT_LAT];
            r_rsp_result <= m_result;
        end else begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign m_a        = r_m_a;
    assign m_b        = r_m_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

`ifdef MULT_ARB_STATS_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_issue_cnt <= '0;
        else if (w_fire) r_issue_cnt <= r_issue_cnt + 16'd1;
    end

    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench: three arbiters (latency 0, 2, 3) share one stimulus stream.
// Each has its own multiplier model and response monitor.
module tb_mult_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
        int          acc;
        bit          cxl;
    } exp_t;

    localparam logic [15:0] PROD [4] = '{16'd12, 16'd132, 16'd56, 16'hFE01};

    logic        clk = 1'b0;
    logic        clr_n;
    logic        issue_en;
    logic [3:0]  req_valid;
    logic [7:0]  op_a [4];
    logic [7:0]  op_b [4];
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [3:0]  req_ready  [3];
    logic [7:0]  m_a        [3];
    logic [7:0]  m_b        [3];
    logic        rsp_valid  [3];
    logic [1:0]  rsp_id     [3];
    logic [15:0] rsp_result [3];
`ifdef MULT_ARB_STATS_EN
    logic [15:0] issue_cnt  [3];
`endif

    exp_t exp_q [$];
    int   cyc  = 0;
    int   nvec = 0;
    int   nmis = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = op_a[i];
            req_b[i*8 +: 8] = op_b[i];
        end
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d @cyc %0d: got %0h, expected %0h",
                     nm, k, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 0 : ((k == 1) ? 2 : 3);
        logic [15:0] w_res;
        int rd = 0;

        mult_arbiter #(
            .WIDTH(8), .NREQ(4), .MULT_LAT(LAT), .IDW(2)
        ) u_dut (
            .clk        (clk),
            .clr_n      (clr_n),
            .issue_en   (issue_en),
            .req_valid  (req_valid),
            .req_a      (req_a),
            .req_b      (req_b),
            .req_ready  (req_ready[k]),
            .m_a        (m_a[k]),
            .m_b        (m_b[k]),
            .m_result   (w_res),
            .rsp_valid  (rsp_valid[k]),
            .rsp_id     (rsp_id[k]),
            .rsp_result (rsp_result[k])
`ifdef MULT_ARB_STATS_EN
            ,
            .issue_cnt  (issue_cnt[k])
`endif
        );

        if (LAT == 0) begin : g_comb
            assign w_res = {8'd0, m_a[k]} * {8'd0, m_b[k]};
        end else begin : g_pipe
            logic [15:0] p [LAT];
            always @(posedge clk) begin
                p[0] <= {8'd0, m_a[k]} * {8'd0, m_b[k]};
                for (int s = 1; s < LAT; s++) p[s] <= p[s-1];
            end
            assign w_res = p[LAT-1];
        end

        always @(negedge clk) begin
            while (rd < exp_q.size() && exp_q[rd].cxl) rd++;
            if (rsp_valid[k] === 1'b1) begin
                if (rd < exp_q.size()) begin
                    chk("rsp_id", k, 32'(rsp_id[k]), 32'(exp_q[rd].id));
                    chk("rsp_result", k, 32'(rsp_result[k]), 32'(exp_q[rd].p));
                    chk("rsp_cycle", k, cyc, exp_q[rd].acc + LAT + 1);
                    rd++;
                end else begin
                    chk("rsp_unexpected", k, 32'(rsp_valid[k]), 32'd0);
                end
            end
        end

        initial begin : p_end
            int r;
            wait (done);
            r = rd;
            while (r < exp_q.size() && exp_q[r].cxl) r++;
            chk("rsp_missing", k, r, exp_q.size());
        end
    end

    // Drive one cycle; exp_id is the hand-predicted grant (-1 for none).
    task automatic step(input logic en, input logic [3:0] v, input int exp_id);
        exp_t e;
        issue_en  = en;
        req_valid = v;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("req_ready", k, 32'(req_ready[k]),
                (exp_id < 0) ? 32'd0 : (32'd1 << exp_id));
        if (exp_id >= 0) begin
            e.id  = 2'(exp_id);
            e.p   = PROD[exp_id];
            e.acc = cyc + 1;
            e.cxl = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero();
        for (int k = 0; k < 3; k++) begin
            chk("rst_m_a", k, 32'(m_a[k]), 32'd0);
            chk("rst_m_b", k, 32'(m_b[k]), 32'd0);
            chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_id", k, 32'(rsp_id[k]), 32'd0);
            chk("rst_rsp_result", k, 32'(rsp_result[k]), 32'd0);
            chk("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
        end
    endtask

    initial begin
        op_a = '{8'd3, 8'd12, 8'd7, 8'hFF};
        op_b = '{8'd4, 8'd11, 8'd8, 8'hFF};
        clr_n     = 1'b0;
        issue_en  = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        clr_n     = 1'b1;
        req_valid = 4'h0;

        for (int i = 0; i < 8; i++) step(1'b1, 4'hF, i % 4);

        step(1'b1, 4'b0010, 1);
        repeat (3) step(1'b1, 4'b0000, -1);
        step(1'b1, 4'b1000, 3);
        step(1'b1, 4'b1011, 0);
        step(1'b1, 4'b1001, 3);
        step(1'b1, 4'b1001, 0);

        step(1'b0, 4'b0100, -1);
        step(1'b1, 4'b0000, -1);
        step(1'b1, 4'b0101, 2);

        step(1'b1, 4'b0001, 0);
        step(1'b1, 4'b0010, 1);
        step(1'b0, 4'b1111, -1);
        repeat (5) step(1'b1, 4'b0000, -1);

        step(1'b1, 4'b0100, 2);
        step(1'b1, 4'b0001, 0);
        foreach (exp_q[i]) exp_q[i].cxl = 1'b1;
        req_valid = 4'hF;
        clr_n = 1'b0;
        #1;
        check_zero();
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        step(1'b1, 4'hF, 0);
        step(1'b1, 4'hF, 1);
        step(1'b1, 4'hF, 2);
        step(1'b1, 4'hF, 3);
        step(1'b1, 4'hF, 0);
`ifdef MULT_ARB_STATS_EN
        for (int k = 0; k < 3; k++)
            chk("issue_cnt5", k, 32'(issue_cnt[k]), 32'd5);
        for (int i = 0; i < 65531; i++) step(1'b1, 4'hF, (i + 1) % 4);
        for (int k = 0; k < 3; k++)
            chk("issue_cnt_wrap", k, 32'(issue_cnt[k]), 32'd0);
`endif
        repeat (6) step(1'b1, 4'b0000, -1);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
